// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction-fetch stage between the PC register and IF/ID.
//
// Presents the current PC to instruction memory over a req/ready handshake
// and captures the returned word into the IF/ID register. A one-entry skid
// buffer absorbs decode back-pressure. A flush discards in-flight fetches;
// a request that was already issued but not yet answered is retired in the
// DROP state so the memory handshake stays protocol-clean.
// All state updates happen on the falling edge of clk, matching the PC
// register. Reset is synchronous and active-high.
//
// Optional feature macro: IF_NOP_BUBBLE_EN -- when defined, an invalid IF/ID
// entry (bubble, flush, reset) always carries a nop word and no exception.
//
// Ports:
//   clk, reset            clock (falling-edge state) / sync active-high reset
//   pc                    current PC from the PC register
//   pc_stall              hold the PC this cycle (combinational)
//   imem_req, imem_addr   fetch request / address (combinational)
//   imem_ready,imem_rdata response valid (may be same cycle) / fetched word
//   id_stall              decode cannot accept a new instruction
//   flush                 redirect; kill everything younger than the branch
//   if_valid, if_inst     IF/ID valid / instruction
//   if_pc, if_pc4         IF/ID PC / PC + 4
//   if_exc                misaligned-fetch exception flag
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  pc_stall,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  id_stall,
  input  logic                  flush,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [PC_WIDTH-1:0]   if_pc4,
  output logic                  if_exc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  if_valid_q, if_valid_d;
  logic [INST_WIDTH-1:0] if_inst_q,  if_inst_d;
  logic [PC_WIDTH-1:0]   if_pc_q,    if_pc_d;
  logic [PC_WIDTH-1:0]   if_pc4_q,   if_pc4_d;
  logic                  if_exc_q,   if_exc_d;

  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0]   skid_pc_q,   skid_pc_d;
  logic                  skid_exc_q,  skid_exc_d;

  logic [PC_WIDTH-1:0]   drop_addr_q, drop_addr_d;

  logic                  aligned;
  logic                  fetch_done;
  logic [INST_WIDTH-1:0] fetch_word;

  // Misaligned fetches never touch memory; they complete as a flagged nop.
  assign aligned    = (pc[1:0] == 2'b00);
  assign fetch_word = aligned ? imem_rdata : '0;

  // State register (falling edge, reset folded into next-state logic)
  always_ff @(negedge clk) begin
    state_q     <= state_d;
    if_valid_q  <= if_valid_d;
    if_inst_q   <= if_inst_d;
    if_pc_q     <= if_pc_d;
    if_pc4_q    <= if_pc4_d;
    if_exc_q    <= if_exc_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
    skid_exc_q  <= skid_exc_d;
    drop_addr_q <= drop_addr_d;
  end

  // Next-state, handshake and IF/ID update logic
  always_comb begin
    state_d     = state_q;
    if_valid_d  = if_valid_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    if_exc_d    = if_exc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_exc_d  = skid_exc_q;
    drop_addr_d = drop_addr_q;
    pc_stall    = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc;
    fetch_done  = 1'b0;

    if (reset) begin
      state_d    = S_REQ;
      if_valid_d = 1'b0;
      if_inst_d  = '0;
      if_pc_d    = '0;
      if_pc4_d   = PC_WIDTH'(4);
      if_exc_d   = 1'b0;
    end else begin
      // Handshake outputs depend only on the current state
      case (state_q)
        S_REQ: begin
          imem_req   = aligned;
          fetch_done = !aligned || imem_ready;
        end
        S_DROP: begin
          imem_req  = 1'b1;
          imem_addr = drop_addr_q;
        end
        default: ;
      endcase

      if (flush) begin
        // Let the PC take the redirect; any same-cycle response is dropped.
        if_valid_d = 1'b0;
        if (state_q == S_DROP) begin
          // The abandoned request is still owed a response unless it lands now.
          state_d = imem_ready ? S_REQ : S_DROP;
        end else if (state_q == S_REQ && imem_req && !imem_ready) begin
          state_d     = S_DROP;
          drop_addr_d = pc;
        end else begin
          state_d = S_REQ;
        end
      end else begin
        case (state_q)
          S_REQ: begin
            if (fetch_done) begin
              if (!if_valid_q || !id_stall) begin
                if_valid_d = 1'b1;
                if_inst_d  = fetch_word;
                if_pc_d    = pc;
                if_pc4_d   = pc + PC_WIDTH'(4);
                if_exc_d   = !aligned;
              end else begin
                skid_inst_d = fetch_word;
                skid_pc_d   = pc;
                skid_exc_d  = !aligned;
                state_d     = S_FULL;
              end
            end else begin
              pc_stall = 1'b1;
              if (!id_stall) if_valid_d = 1'b0;
            end
          end
          S_FULL: begin
            pc_stall = 1'b1;
            if (!id_stall) begin
              if_valid_d = 1'b1;
              if_inst_d  = skid_inst_q;
              if_pc_d    = skid_pc_q;
              if_pc4_d   = skid_pc_q + PC_WIDTH'(4);
              if_exc_d   = skid_exc_q;
              state_d    = S_REQ;
            end
          end
          S_DROP: begin
            pc_stall = 1'b1;
            if (!id_stall) if_valid_d = 1'b0;
            if (imem_ready) state_d = S_REQ;
          end
          default: state_d = S_REQ;
        endcase
      end
    end

`ifdef IF_NOP_BUBBLE_EN
    // Invalid entries always look like a clean nop to decode.
    if (!if_valid_d) begin
      if_inst_d = '0;
      if_exc_d  = 1'b0;
    end
`endif
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign if_pc4   = if_pc4_q;
  assign if_exc   = if_exc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by random traffic, all
// checked against a queue-level model of the fetch stage and a small memory.
module tb_inst_fetch;
  localparam int unsigned PW = 32;
  localparam int unsigned IW = 32;

`ifdef IF_NOP_BUBBLE_EN
  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
`else
  localparam logic [31:0] BUBBLE_INST = 32'h3C1D_1000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pc;
  logic          pc_stall;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic          id_stall;
  logic          flush;
  logic          if_valid;
  logic [IW-1:0] if_inst;
  logic [PW-1:0] if_pc;
  logic [PW-1:0] if_pc4;
  logic          if_exc;

  always #5 clk = ~clk;

  inst_fetch #(.PC_WIDTH(PW), .INST_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc4(if_pc4), .if_exc(if_exc)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } entry_t;

  // Model: instructions held by the stage, oldest (the one in IF/ID) first.
  entry_t      pipe[$];
  logic        drop;
  logic [31:0] drop_addr;
  logic [31:0] sh_inst, sh_pc;
  logic        sh_exc;
  logic [31:0] pc_r;
  // Memory: one outstanding request with a chosen latency.
  logic        mem_busy;
  int          mem_left;
  int          lat_mode;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] r;
    if (a == 32'hF000_0000) return 32'h3C1D_1000;
    r = a * 32'h9E37_79B1;
    return r ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model, then check IF/ID after the falling edge.
  task automatic cyc(input logic rst, input logic fl, input logic stl, input logic [31:0] tgt);
    logic        aligned, can_fetch, req, rdy, done, stall;
    logic [31:0] addr, rdata, word;
    entry_t      e;
    aligned   = (pc_r[1:0] == 2'b00);
    can_fetch = !drop && (pipe.size() < 2);
    req       = !rst && (drop || (can_fetch && aligned));
    addr      = drop ? drop_addr : pc_r;
    rdy       = 1'b0;
    if (rst) begin
      mem_busy = 1'b0;
    end else if (req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
      end
      if (mem_left == 0) begin
        rdy      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_left--;
      end
    end
    rdata = rdy ? memword(addr) : $urandom;
    done  = !rst && can_fetch && (!aligned || rdy);
    stall = !rst && !fl && !done;
    word  = aligned ? rdata : 32'h0;

    reset = rst; pc = pc_r; flush = fl; id_stall = stl;
    imem_ready = rdy; imem_rdata = rdata;

    @(posedge clk);
    chk("pc_stall", 32'(pc_stall), 32'(stall));
    chk("imem_req", 32'(imem_req), 32'(req));
    if (req) chk("imem_addr", imem_addr, addr);

    if (rst) begin
      pipe.delete();
      drop = 1'b0; sh_inst = '0; sh_pc = '0; sh_exc = 1'b0;
    end else if (fl) begin
      pipe.delete();
      if (drop) drop = !rdy;
      else if (req && !rdy) begin
        drop = 1'b1;
        drop_addr = pc_r;
      end
    end else begin
      if (drop && rdy) drop = 1'b0;
      if (!stl && pipe.size() > 0) void'(pipe.pop_front());
      if (done) begin
        e.inst = word; e.pc = pc_r; e.exc = !aligned;
        pipe.push_back(e);
      end
    end
    if (pipe.size() > 0) begin
      sh_inst = pipe[0].inst; sh_pc = pipe[0].pc; sh_exc = pipe[0].exc;
    end
`ifdef IF_NOP_BUBBLE_EN
    else begin
      sh_inst = '0; sh_exc = 1'b0;
    end
`endif
    if (!rst) pc_r = fl ? tgt : (stall ? pc_r : pc_r + 32'd4);

    @(negedge clk); #1;
    chk("if_valid", 32'(if_valid), 32'(pipe.size() > 0));
    chk("if_inst", if_inst, sh_inst);
    chk("if_pc", if_pc, sh_pc);
    chk("if_pc4", if_pc4, sh_pc + 32'd4);
    chk("if_exc", 32'(if_exc), 32'(sh_exc));
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; pc = '0; flush = 1'b0; id_stall = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    drop = 1'b0; drop_addr = '0; mem_busy = 1'b0; mem_left = 0;
    sh_inst = '0; sh_pc = '0; sh_exc = 1'b0; pc_r = '0; lat_mode = 0;
    @(negedge clk); #1;

    // Reset values
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h4);
    chk("rst_exc", 32'(if_exc), 32'h0);

    // First fetch, same-cycle ready
    pc_r = 32'hF000_0000;
    cyc(0, 0, 0, 0);
    chk("first_valid", 32'(if_valid), 32'h1);
    chk("first_inst", if_inst, 32'h3C1D_1000);
    chk("first_pc", if_pc, 32'hF000_0000);
    chk("first_pc4", if_pc4, 32'hF000_0004);

    // Two-cycle-late memory; the first waiting cycle is a bubble
    lat_mode = 2;
    cyc(0, 0, 0, 0);
    chk("bubble_valid", 32'(if_valid), 32'h0);
    chk("bubble_inst", if_inst, BUBBLE_INST);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("late_valid", 32'(if_valid), 32'h1);
    chk("late_pc", if_pc, 32'hF000_0004);

    // Decode stalls three cycles with zero-wait memory
    lat_mode = 0;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("stall_hold_pc", if_pc, 32'hF000_0004);
    cyc(0, 0, 0, 0);
    chk("skid_out_pc", if_pc, 32'hF000_0008);
    cyc(0, 0, 0, 0);
    chk("after_skid_pc", if_pc, 32'hF000_000C);

    // Flush while the request at F0000010 is pending
    lat_mode = 3;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 32'hF000_0100);
    lat_mode = 0;
    cyc(0, 0, 0, 0);
    chk("drop_req", 32'(imem_req), 32'h1);
    chk("drop_addr", imem_addr, 32'hF000_0010);
    cyc(0, 0, 0, 0);
    chk("drop_discard", 32'(if_valid), 32'h0);
    cyc(0, 0, 0, 0);
    chk("target_pc", if_pc, 32'hF000_0100);
    chk("target_inst", if_inst, memword(32'hF000_0100));

    // Misaligned redirect target
    cyc(0, 1, 0, 32'hF000_0002);
    cyc(0, 0, 0, 0);
    chk("mis_valid", 32'(if_valid), 32'h1);
    chk("mis_exc", 32'(if_exc), 32'h1);
    chk("mis_inst", if_inst, 32'h0);
    chk("mis_pc", if_pc, 32'hF000_0002);

    // Reset in the middle of DROP
    pc_r = 32'hF000_0200; lat_mode = 3;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 32'hF000_0300);
    cyc(1, 0, 0, 0);
    lat_mode = 0;
    chk("rst_drop_addr", imem_addr, 32'hF000_0300);
    cyc(0, 0, 0, 0);
    chk("rst_drop_pc", if_pc, 32'hF000_0300);

    // Random traffic
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      t[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) == 0), t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
